frame_destuffer: RTL and testbench

Serial receive-side deframer: samples the RX line at the programmed bit period, removes the zero bits the transmit-side stuffer inserts, and detects 0x7E flags and abort sequences. It delivers frame payload bytes to the CPU-facing register logic through a single holding register with a read handshake. It sits between the RX pin and the data/status registers of the serial peripheral, mirroring the transmitter/stuffer chain on the TX side.

---
 rtl/serial_pkg.sv | 17 +
 rtl/rx_bitsampler.sv | 61 ++++++
 rtl/frame_destuffer.sv | 166 ++++++++++++++++
 tb/tb_frame_destuffer.sv | 259 +++++++++++++++++++++++++
 4 files changed

// File: rtl/serial_pkg.sv
// Shared constants and types for the serial receive path.
// No logic; pure declarations.
// No flow control.
package serial_pkg;

    localparam logic [7:0] FLAG      = 8'h7E;
    localparam int         STUFF_RUN = 5;
    localparam int         ABORT_RUN = 7;
    localparam int         MIN_BAUD  = 2;

    // Framing state: hunting for an opening flag, or inside a frame.
    typedef enum logic {
        RX_HUNT  = 1'b0,
        RX_FRAME = 1'b1
    } rx_state_e;

endpackage

// File: rtl/rx_bitsampler.sv
// RX line synchronizer and bit-period sampler, realigned on every line edge.
// Latency: 2-cycle synchronizer, then one bit_valid_o pulse per bit at mid-period.
// No backpressure: bit_valid_o is a single-cycle strobe the consumer must take.
module rx_bitsampler
    import serial_pkg::*;
(
    input  logic       clk_i,
    input  logic       nrst_i,
    input  logic       en_i,
    input  logic [7:0] baud_i,
    input  logic       rx_i,
    output logic       bit_valid_o,
    output logic       bit_val_o
);

    logic       rx_s1_q;
    logic       rx_s2_q;
    logic       rx_prev_q;
    logic [7:0] phase_q;
    logic [7:0] phase_d;
    logic [7:0] baud_q;
    logic [7:0] baud_d;
    logic       edge_w;
    logic [7:0] phase_cur;
    logic [7:0] baud_cur;

    // Phase tracking: an edge forces this cycle to phase 0; a new bit period
    // is only picked up when the phase restarts, so BAUD changes never cut a bit short.
    always_comb begin
        edge_w    = rx_s2_q ^ rx_prev_q;
        phase_cur = edge_w ? 8'd0 : phase_q;
        baud_cur  = (phase_cur == 8'd0) ? baud_i : baud_q;
        baud_d    = baud_cur;
        phase_d   = (phase_cur >= baud_cur - 8'd1) ? 8'd0 : phase_cur + 8'd1;
        if (!en_i) begin
            phase_d = 8'd0;
            baud_d  = baud_i;
        end
    end

    assign bit_valid_o = en_i && (phase_cur == (baud_cur >> 1));
    assign bit_val_o   = rx_s2_q;

    // Synchronizer flops reset to the idle-high line level to avoid a false edge.
    always_ff @(posedge clk_i) begin
        if (!nrst_i) begin
            rx_s1_q   <= 1'b1;
            rx_s2_q   <= 1'b1;
            rx_prev_q <= 1'b1;
            phase_q   <= 8'd0;
            baud_q    <= 8'd0;
        end else begin
            rx_s1_q   <= rx_i;
            rx_s2_q   <= rx_s1_q;
            rx_prev_q <= rx_s2_q;
            phase_q   <= phase_d;
            baud_q    <= baud_d;
        end
    end

endmodule

// File: rtl/frame_destuffer.sv
// Receive deframer: drops stuffed zeros, finds flags/aborts, assembles payload bytes.
// Latency: outputs register one cycle after the sampling cycle; bytes lag one data bit.
// No backpressure: a byte arriving while DVALID is set overwrites DOUT and sets OVR.
module frame_destuffer
    import serial_pkg::*;
(
    input  logic       CLK,
    input  logic       NRST,
    input  logic       EN,
    input  logic [7:0] BAUD,
    input  logic       RX,
    input  logic       DREAD,
    output logic [7:0] DOUT,
    output logic       DVALID,
    output logic       OVR,
    output logic       INFRAME,
    output logic       FRAME_END,
    output logic       FRAME_ERR,
    output logic       ABORT
);

    localparam logic [2:0] ONES_STUFF = 3'(STUFF_RUN);
    localparam logic [2:0] ONES_FLAG  = 3'(STUFF_RUN + 1);
    localparam logic [2:0] ONES_ABORT = 3'(ABORT_RUN);

    logic       rx_en;
    logic       bit_valid;
    logic       bit_val;
    logic       data_bit;

    rx_state_e  st_q,     st_d;
    logic [2:0] ones_q,   ones_d;
    logic [3:0] cnt_q,    cnt_d;
    logic [7:0] sr_q,     sr_d;
    logic       seen_q,   seen_d;
    logic [7:0] dout_q,   dout_d;
    logic       dvalid_q, dvalid_d;
    logic       ovr_q,    ovr_d;
    logic       fend_q,   fend_d;
    logic       ferr_q,   ferr_d;
    logic       abort_q,  abort_d;

    assign rx_en = EN && (BAUD >= 8'(MIN_BAUD));

    rx_bitsampler u_sampler (
        .clk_i       (CLK),
        .nrst_i      (NRST),
        .en_i        (rx_en),
        .baud_i      (BAUD),
        .rx_i        (RX),
        .bit_valid_o (bit_valid),
        .bit_val_o   (bit_val)
    );

    // Destuffing, flag/abort detection, byte assembly and holding-register update.
    always_comb begin
        st_d     = st_q;
        ones_d   = ones_q;
        cnt_d    = cnt_q;
        sr_d     = sr_q;
        seen_d   = seen_q;
        dout_d   = dout_q;
        dvalid_d = dvalid_q;
        ovr_d    = ovr_q;
        fend_d   = 1'b0;
        ferr_d   = 1'b0;
        abort_d  = 1'b0;
        data_bit = 1'b0;

        if (DREAD && dvalid_q) begin
            dvalid_d = 1'b0;
            ovr_d    = 1'b0;
        end

        if (!rx_en) begin
            st_d   = RX_HUNT;
            ones_d = 3'd0;
            cnt_d  = 4'd0;
            seen_d = 1'b0;
        end else if (bit_valid) begin
            if (!bit_val) begin
                ones_d = 3'd0;
                if (ones_q == ONES_FLAG) begin
                    // Six flag bits are already in the shift register when
                    // the closing zero lands, so cnt==6 means byte-aligned.
                    if (cnt_q == 4'd6) begin
                        fend_d = seen_q;
                    end else begin
                        ferr_d = (st_q == RX_FRAME);
                    end
                    cnt_d  = 4'd0;
                    seen_d = 1'b0;
                    st_d   = RX_FRAME;
                end else if (ones_q < ONES_STUFF) begin
                    data_bit = 1'b1;
                end
                // A zero after exactly five ones is a stuffed bit: dropped.
            end else if (ones_q < ONES_STUFF) begin
                data_bit = 1'b1;
                ones_d   = ones_q + 3'd1;
            end else if (ones_q == ONES_STUFF) begin
                ones_d = ONES_FLAG;
            end else begin
                ones_d  = ONES_ABORT;
                abort_d = (st_q == RX_FRAME);
                st_d    = RX_HUNT;
                cnt_d   = 4'd0;
                seen_d  = 1'b0;
            end

            // Delivery is deferred by one data bit so flag-prefix bits never form a byte.
            if (data_bit && (st_q == RX_FRAME)) begin
                sr_d = {bit_val, sr_q[7:1]};
                if (cnt_q == 4'd8) begin
                    cnt_d    = 4'd1;
                    seen_d   = 1'b1;
                    dout_d   = sr_q;
                    dvalid_d = 1'b1;
                    if (dvalid_q && !DREAD) begin
                        ovr_d = 1'b1;
                    end
                end else begin
                    cnt_d = cnt_q + 4'd1;
                end
            end
        end
    end

    // State and output registers with synchronous active-low reset.
    always_ff @(posedge CLK) begin
        if (!NRST) begin
            st_q     <= RX_HUNT;
            ones_q   <= 3'd0;
            cnt_q    <= 4'd0;
            sr_q     <= 8'd0;
            seen_q   <= 1'b0;
            dout_q   <= 8'd0;
            dvalid_q <= 1'b0;
            ovr_q    <= 1'b0;
            fend_q   <= 1'b0;
            ferr_q   <= 1'b0;
            abort_q  <= 1'b0;
        end else begin
            st_q     <= st_d;
            ones_q   <= ones_d;
            cnt_q    <= cnt_d;
            sr_q     <= sr_d;
            seen_q   <= seen_d;
            dout_q   <= dout_d;
            dvalid_q <= dvalid_d;
            ovr_q    <= ovr_d;
            fend_q   <= fend_d;
            ferr_q   <= ferr_d;
            abort_q  <= abort_d;
        end
    end

    assign DOUT      = dout_q;
    assign DVALID    = dvalid_q;
    assign OVR       = ovr_q;
    assign INFRAME   = (st_q == RX_FRAME);
    assign FRAME_END = fend_q;
    assign FRAME_ERR = ferr_q;
    assign ABORT     = abort_q;

endmodule

// File: tb/tb_frame_destuffer.sv
// Directed bench for frame_destuffer: bit-serial stimulus with a stuffing transmitter.
// Latency: checks taken on the falling edge after whole bits have been sent.
// Backpressure: DREAD issued automatically or by hand depending on the test.
module tb_frame_destuffer;
    import serial_pkg::*;

    localparam int BIT_CLKS = 16;

    logic       CLK = 1'b0;
    logic       NRST;
    logic       EN;
    logic [7:0] BAUD;
    logic       RX;
    logic       DREAD;
    logic [7:0] DOUT;
    logic       DVALID;
    logic       OVR;
    logic       INFRAME;
    logic       FRAME_END;
    logic       FRAME_ERR;
    logic       ABORT;

    int         n_checks = 0;
    int         n_fail   = 0;
    int         tx_ones  = 0;
    logic       auto_rd  = 1'b0;

    logic [7:0] rx_q[$];
    int         fe_cnt   = 0;
    int         ferr_cnt = 0;
    int         ab_cnt   = 0;
    logic       dv_prev  = 1'b0;
    logic [7:0] dout_prev = 8'd0;

    int         q0, fe0, fer0, ab0;

    frame_destuffer dut (
        .CLK       (CLK),
        .NRST      (NRST),
        .EN        (EN),
        .BAUD      (BAUD),
        .RX        (RX),
        .DREAD     (DREAD),
        .DOUT      (DOUT),
        .DVALID    (DVALID),
        .OVR       (OVR),
        .INFRAME   (INFRAME),
        .FRAME_END (FRAME_END),
        .FRAME_ERR (FRAME_ERR),
        .ABORT     (ABORT)
    );

    always #5 CLK = ~CLK;

    // Record every newly presented byte and count the one-cycle event pulses.
    always @(negedge CLK) begin
        if (DVALID && (!dv_prev || (DOUT != dout_prev))) begin
            rx_q.push_back(DOUT);
        end
        dv_prev   <= DVALID;
        dout_prev <= DOUT;
        if (FRAME_END) fe_cnt   <= fe_cnt + 1;
        if (FRAME_ERR) ferr_cnt <= ferr_cnt + 1;
        if (ABORT)     ab_cnt   <= ab_cnt + 1;
    end

    task automatic check_val(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, obs, exp);
        end
    endtask

    task automatic send_raw(input logic b);
        RX = b;
        for (int i = 0; i < BIT_CLKS; i++) begin
            @(negedge CLK);
            if (auto_rd && DVALID && !DREAD) DREAD = 1'b1;
            else                             DREAD = 1'b0;
        end
    endtask

    task automatic send_data(input logic b);
        send_raw(b);
        if (b) begin
            tx_ones++;
            if (tx_ones == STUFF_RUN) begin
                send_raw(1'b0);
                tx_ones = 0;
            end
        end else begin
            tx_ones = 0;
        end
    endtask

    task automatic send_byte(input logic [7:0] d);
        for (int i = 0; i < 8; i++) send_data(d[i]);
    endtask

    task automatic send_flag();
        logic [7:0] f;
        f = FLAG;
        for (int i = 0; i < 8; i++) send_raw(f[i]);
        tx_ones = 0;
    endtask

    task automatic dread_pulse();
        DREAD = 1'b1;
        @(negedge CLK);
        DREAD = 1'b0;
        @(negedge CLK);
    endtask

    task automatic snap();
        q0   = rx_q.size();
        fe0  = fe_cnt;
        fer0 = ferr_cnt;
        ab0  = ab_cnt;
    endtask

    initial begin
        NRST  = 1'b0;
        EN    = 1'b1;
        BAUD  = 8'd16;
        RX    = 1'b1;
        DREAD = 1'b0;
        repeat (3) @(negedge CLK);

        // Reset state
        check_val("rst_dout",    DOUT,      0);
        check_val("rst_dvalid",  DVALID,    0);
        check_val("rst_ovr",     OVR,       0);
        check_val("rst_inframe", INFRAME,   0);
        check_val("rst_pulses",  {FRAME_END, FRAME_ERR, ABORT}, 0);
        NRST = 1'b1;
        for (int i = 0; i < 10; i++) send_raw(1'b1);

        // T1: two bytes read between deliveries, clean close
        auto_rd = 1'b1;
        snap();
        send_flag();
        send_byte(8'h41);
        send_byte(8'hA5);
        send_flag();
        check_val("t1_nbytes",  rx_q.size() - q0, 2);
        check_val("t1_byte0",   rx_q[q0],         8'h41);
        check_val("t1_byte1",   rx_q[q0 + 1],     8'hA5);
        check_val("t1_fend",    fe_cnt - fe0,     1);
        check_val("t1_ferr",    ferr_cnt - fer0,  0);
        check_val("t1_abort",   ab_cnt - ab0,     0);
        check_val("t1_inframe", INFRAME,          1);
        check_val("t1_ovr",     OVR,              0);

        // T2: 0xFF needs a stuffed zero
        snap();
        send_flag();
        send_byte(8'hFF);
        send_flag();
        check_val("t2_nbytes", rx_q.size() - q0, 1);
        check_val("t2_byte",   rx_q[q0],         8'hFF);
        check_val("t2_fend",   fe_cnt - fe0,     1);
        check_val("t2_ferr",   ferr_cnt - fer0,  0);

        // T3: overrun without reads
        auto_rd = 1'b0;
        snap();
        send_flag();
        send_byte(8'h12);
        send_byte(8'h34);
        send_flag();
        check_val("t3_dout",   DOUT,         8'h34);
        check_val("t3_dvalid", DVALID,       1);
        check_val("t3_ovr",    OVR,          1);
        check_val("t3_fend",   fe_cnt - fe0, 1);
        dread_pulse();
        check_val("t3_rd_dvalid", DVALID, 0);
        check_val("t3_rd_ovr",    OVR,    0);
        dread_pulse();
        check_val("t3_idle_rd_dvalid", DVALID, 0);
        check_val("t3_idle_rd_dout",   DOUT,   8'h34);

        // T4: abort after one byte, trailing data ignored
        auto_rd = 1'b1;
        snap();
        send_flag();
        send_byte(8'h55);
        for (int i = 0; i < 7; i++) send_raw(1'b1);
        check_val("t4_byte",    rx_q[q0],        8'h55);
        check_val("t4_abort",   ab_cnt - ab0,    1);
        check_val("t4_inframe", INFRAME,         0);
        check_val("t4_fend",    fe_cnt - fe0,    0);
        check_val("t4_ferr",    ferr_cnt - fer0, 0);
        snap();
        send_byte(8'h00);
        send_byte(8'h81);
        check_val("t4_ignored", rx_q.size() - q0, 0);
        check_val("t4_dvalid",  DVALID,           0);

        // T5: 11 data bits then a flag is misaligned
        snap();
        send_flag();
        for (int i = 0; i < 11; i++) send_data(1'b0);
        send_flag();
        check_val("t5_ferr",   ferr_cnt - fer0,  1);
        check_val("t5_fend",   fe_cnt - fe0,     0);
        check_val("t5_nbytes", rx_q.size() - q0, 2);
        check_val("t5_byte0",  rx_q[q0],         8'h00);
        check_val("t5_byte1",  rx_q[q0 + 1],     8'hF0);
        snap();
        send_flag();
        send_flag();
        check_val("t5_fill_pulses", (fe_cnt - fe0) + (ferr_cnt - fer0) + (ab_cnt - ab0), 0);
        check_val("t5_fill_inframe", INFRAME, 1);

        // T6: reset mid-byte, then EN low mid-frame, then a good frame
        auto_rd = 1'b0;
        send_flag();
        send_byte(8'hC3);
        for (int i = 0; i < 3; i++) send_data(1'b0);
        check_val("t6_pre_dout",   DOUT,   8'hC3);
        check_val("t6_pre_dvalid", DVALID, 1);
        NRST = 1'b0;
        @(negedge CLK);
        NRST = 1'b1;
        check_val("t6_rst_dout",    DOUT,    0);
        check_val("t6_rst_dvalid",  DVALID,  0);
        check_val("t6_rst_ovr",     OVR,     0);
        check_val("t6_rst_inframe", INFRAME, 0);
        for (int i = 0; i < 4; i++) send_data(1'b0);
        snap();
        send_flag();
        check_val("t6_open_inframe", INFRAME, 1);
        send_raw(1'b1);
        send_raw(1'b0);
        send_raw(1'b1);
        EN = 1'b0;
        for (int i = 0; i < 3; i++) send_raw(1'b1);
        check_val("t6_en_inframe", INFRAME, 0);
        check_val("t6_en_dvalid",  DVALID,  0);
        check_val("t6_en_pulses",  (fe_cnt - fe0) + (ferr_cnt - fer0) + (ab_cnt - ab0), 0);
        EN = 1'b1;
        auto_rd = 1'b1;
        send_raw(1'b1);
        send_raw(1'b1);
        snap();
        send_flag();
        send_byte(8'h5A);
        send_flag();
        check_val("t6_nbytes", rx_q.size() - q0, 1);
        check_val("t6_byte",   rx_q[q0],         8'h5A);
        check_val("t6_fend",   fe_cnt - fe0,     1);
        check_val("t6_ferr",   ferr_cnt - fer0,  0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
